// File: rtl/viterbi_pkg.sv
// Shared Viterbi link definitions: code parameters and the types that the
// encoder, decoder and reference models all use.
package viterbi_pkg;

  localparam int unsigned  K  = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic {DATA, TAIL} enc_state_t;

  typedef logic [1:0] symbol_t;

endpackage

// File: rtl/conv_branch.sv
// Combinational rate-1/2 branch output: maps a K-bit trellis window to its
// code symbol {G0 parity, G1 parity}. window_i[0] is the newest input bit.
module conv_branch
  import viterbi_pkg::*;
#(
  parameter int unsigned  K  = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic [K-1:0] window_i,
  output symbol_t      symbol_o
);

  assign symbol_o = {^(window_i & G0), ^(window_i & G1)};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with zero-tail termination and a
// single-entry registered output slot on a valid/ready stream.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int unsigned  K         = viterbi_pkg::K,
  parameter logic [K-1:0] G0        = viterbi_pkg::G0,
  parameter logic [K-1:0] G1        = viterbi_pkg::G1,
  parameter int unsigned  FRAME_LEN = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  output logic    in_ready,
  input  logic    in_bit,
  output logic    out_valid,
  input  logic    out_ready,
  output symbol_t out_pair,
  output logic    out_last,
  output logic    busy
);

  localparam int unsigned   CW        = $clog2(FRAME_LEN + 1);
  localparam int unsigned   TW        = $clog2(K);
  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  enc_state_t    state_q, state_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
  logic          out_valid_q, out_valid_d;
  symbol_t       out_pair_q, out_pair_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;

  logic          slot_free;
  logic          load;
  logic          cur_bit;
  logic [K-1:0]  window;
  symbol_t       sym;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == DATA) && slot_free;
  assign cur_bit   = (state_q == DATA) ? in_bit : 1'b0;
  // sr_q[0] is the most recent past input, so the window is {history, current}
  assign window    = {sr_q, cur_bit};
  assign load      = (state_q == DATA) ? (in_valid && slot_free) : slot_free;

  conv_branch #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_branch (
    .window_i (window),
    .symbol_o (sym)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q;
    out_pair_d  = out_pair_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;

    // Clear first so a same-edge first-bit acceptance below keeps busy set
    if (out_valid_q && out_ready && out_last_q) begin
      busy_d = 1'b0;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_pair_d  = sym;
      out_last_d  = 1'b0;
      sr_d        = window[K-2:0];
      unique case (state_q)
        DATA: begin
          busy_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
            state_d    = TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        TAIL: begin
          if (tail_cnt_q == LAST_TAIL) begin
            out_last_d = 1'b1;
            tail_cnt_d = '0;
            state_d    = DATA;
          end else begin
            tail_cnt_d = tail_cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end else if (slot_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DATA;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      out_pair_q  <= out_pair_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pair  = out_pair_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: FRAME_LEN=4 and FRAME_LEN=16 instances
// checked against hand-computed symbol sequences.
module tb_conv_encoder;
  import viterbi_pkg::*;

  logic    clk;
  logic    rst_n;

  logic    in_valid, in_ready, in_bit, out_valid, out_ready, out_last, busy;
  symbol_t out_pair;

  logic    v16, ir16, b16, ov16, r16, ol16, bz16;
  symbol_t op16;

  int unsigned n_cmp;
  int unsigned n_err;

  conv_encoder #(
    .K         (3),
    .G0        (3'b111),
    .G1        (3'b101),
    .FRAME_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .busy      (busy)
  );

  conv_encoder #(
    .K         (3),
    .G0        (3'b111),
    .G1        (3'b101),
    .FRAME_LEN (16)
  ) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16),
    .in_ready  (ir16),
    .in_bit    (b16),
    .out_valid (ov16),
    .out_ready (r16),
    .out_pair  (op16),
    .out_last  (ol16),
    .busy      (bz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bits/exp are listed in stream order (index 0 first); mode 1 toggles out_ready.
  task automatic run4(input string tag, input logic [0:7] bits, input logic [0:11][1:0] exp,
                      input int unsigned nf, input int unsigned mode, input int unsigned gap,
                      output int unsigned cyc, output int unsigned busy_cyc,
                      output int unsigned nrdy_cyc, output int unsigned vlow_cyc);
    int unsigned bi, si, idle, t, nbits, nsym;
    bi = 0; si = 0; idle = 0; t = 0;
    nbits = nf * 4; nsym = nf * 6;
    busy_cyc = 0; nrdy_cyc = 0; vlow_cyc = 0;
    while (si < nsym && t < 200) begin
      @(negedge clk);
      in_valid  = (bi < nbits) && (idle == 0);
      in_bit    = in_valid ? bits[bi] : 1'b0;
      out_ready = (mode == 0) ? 1'b1 : ((t % 2) == 0);
      #1;
      if (out_valid) begin
        check_eq({tag, "_pair"}, out_pair, exp[si]);
        check_eq({tag, "_last"}, out_last, (si % 6) == 5);
      end else if (t >= 1) begin
        vlow_cyc++;
      end
      if (busy) busy_cyc++;
      if (!in_ready) nrdy_cyc++;
      if (in_valid && in_ready) begin
        bi++;
        idle = gap;
      end else if (idle > 0) begin
        idle--;
      end
      if (out_valid && out_ready) si++;
      t++;
    end
    check_eq({tag, "_nsym"}, si, nsym);
    cyc = t;
    @(negedge clk);
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq({tag, "_idle_busy"}, busy, 1'b0);
    check_eq({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int unsigned cyc, bc, nr, vl, si, bi, t;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    v16 = 1'b0; b16 = 1'b0; r16 = 1'b1;
    #2;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_pair", out_pair, 2'b00);
    check_eq("rst_last", out_last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1,0,1,1 -> 11,10,00,01,01,11
    run4("f1", 8'b1011_0000, 24'b11_10_00_01_01_11_00_00_00_00_00_00, 1, 0, 0, cyc, bc, nr, vl);
    check_eq("f1_cycles", cyc, 7);
    check_eq("f1_busy_cyc", bc, 6);
    check_eq("f1_nrdy_cyc", nr, 2);
    check_eq("f1_vlow", vl, 0);

    run4("stall", 8'b1011_0000, 24'b11_10_00_01_01_11_00_00_00_00_00_00, 1, 1, 0, cyc, bc, nr, vl);

    // 1111 then 0000 with no gap: 11,01,10,10,01,11 then 00 x6
    run4("b2b", 8'b1111_0000, 24'b11_01_10_10_01_11_00_00_00_00_00_00, 2, 0, 0, cyc, bc, nr, vl);
    check_eq("b2b_cycles", cyc, 13);
    check_eq("b2b_busy_cyc", bc, 12);
    check_eq("b2b_nrdy_cyc", nr, 4);
    check_eq("b2b_vlow", vl, 0);

    run4("gap", 8'b1011_0000, 24'b11_10_00_01_01_11_00_00_00_00_00_00, 1, 0, 3, cyc, bc, nr, vl);
    check_eq("gap_cycles", cyc, 16);
    check_eq("gap_vlow", vl, 9);
    check_eq("gap_nrdy_cyc", nr, 2);

    // Reset after two accepted bits of 1,0,1,1
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_bit = (i == 0); out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; in_bit = 1'b0;
    #1;
    check_eq("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_pair", out_pair, 2'b00);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_eq("post_rst_quiet", out_valid, 1'b0);
    end
    run4("rst", 8'b1000_0000, 24'b11_10_11_00_00_00_00_00_00_00_00_00, 1, 0, 0, cyc, bc, nr, vl);
    check_eq("rst_cycles", cyc, 7);

    // All-zero frame on the FRAME_LEN=16 instance: 18 x 00, last on 18th
    si = 0; bi = 0; t = 0;
    while (si < 18 && t < 100) begin
      @(negedge clk);
      v16 = (bi < 16); b16 = 1'b0; r16 = 1'b1;
      #1;
      if (ov16) begin
        check_eq("f16_pair", op16, 2'b00);
        check_eq("f16_last", ol16, si == 17);
      end
      if (v16 && ir16) bi++;
      if (ov16 && r16) si++;
      t++;
    end
    check_eq("f16_nsym", si, 18);
    check_eq("f16_cycles", t, 19);
    @(negedge clk);
    v16 = 1'b0;
    #1;
    check_eq("f16_idle_busy", bz16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
